// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one N-bit adder among NREQ requesters and
// registers the winner's wrap-around sum and ID until the consumer takes it.
module adder_share_arbiter #(
  parameter  int N    = 32,
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_sum,
  output logic [IDW-1:0]      rsp_id
);

  logic [NREQ-1:0][N-1:0] a_v, b_v;
  logic [IDW-1:0]         ptr, ptr_nxt, win;
  logic                   found, can_accept, take;
  logic [N-1:0]           sum_d;

  assign a_v = req_a;
  assign b_v = req_b;

  assign can_accept = !rsp_valid || rsp_ready;
  assign take       = can_accept && found;

  // Scan from ptr upward with modulo-NREQ wrap; first valid requester wins.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // The single shared adder; carry-out is dropped.
  assign sum_d   = a_v[win] + b_v[win];
  assign ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);

  // Ready is held low during reset so nothing is handshaked while state is cleared.
  always_comb begin
    req_ready = '0;
    if (rst_n && take) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (can_accept) begin
      if (found) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= sum_d;
        rsp_id    <= win;
        ptr       <= ptr_nxt;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and one-stage result pipeline that shares a single N-bit adder among NREQ requesters in the RISC-V core. Candidate users include PC+4, branch-target and address-generation paths. Each requester presents two operands with a valid/ready handshake. The block grants one requester per cycle, registers the wrap-around sum with the winner's ID, and holds it until the consumer accepts it.

## Interface
- N, 32, operand/result width in bits (≥ 2).
- NREQ, 4, number of requesters (2..8).
- IDW, derived as clog2(NREQ) (min 1), width of RSP_ID; not overridden.

- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  bit i: requester i presents operands.
- REQ_READY  out  NREQ  bit i: requester i's operands accepted this cycle.
- REQ_A  in  NREQ*N  operand A; requester i at bits [i*N+N-1 : i*N].
- REQ_B  in  NREQ*N  operand B; same packing as REQ_A.
- RSP_VALID  out  1  result register holds an unconsumed result.
- RSP_READY  in  1  consumer takes the result this cycle.
- RSP_SUM  out  N  (A + B) mod 2^N of the granted request.
- RSP_ID  out  IDW  index of the requester that produced RSP_SUM.

## Operation
- State:
  - PTR (IDW bits): round-robin priority pointer.
  - Output register: RSP_VALID, RSP_SUM, RSP_ID.
- can_accept = !RSP_VALID || RSP_READY.
- Grant search (combinational): starting at index PTR, scan PTR, PTR+1, … mod NREQ. The first i with REQ_VALID[i]=1 is the winner.
- When can_accept is 1 and a winner exists:
  - REQ_READY[winner]=1; all other REQ_READY bits are 0.
  - At the edge: RSP_SUM ← A[winner]+B[winner] (carry-out discarded, no overflow flag), RSP_ID ← winner, RSP_VALID ← 1, PTR ← (winner+1) mod NREQ.
- When can_accept is 1 and no winner: REQ_READY=0. If RSP_READY took the previous result, RSP_VALID ← 0. PTR, RSP_SUM and RSP_ID hold.
- When can_accept is 0 (RSP_VALID=1, RSP_READY=0): REQ_READY=0. RSP_SUM, RSP_ID, RSP_VALID and PTR hold.
- Grant is blind to the requester's own handshake. REQ_READY depends combinationally on REQ_VALID and RSP_READY, so requesters must not derive REQ_VALID from REQ_READY.
- Requesters must hold REQ_VALID and their operands stable until their REQ_READY is seen.
- NREQ not a power of two: PTR wraps from NREQ-1 to 0. PTR never takes a value ≥ NREQ.

## Timing
- Reset (RST_N low, asynchronous): RSP_VALID=0, RSP_SUM=0, RSP_ID=0, PTR=0. REQ_READY is forced to all-0 while RST_N is low.
- The first grant is possible in the first cycle after RST_N deasserts.
- Latency: request accepted at edge t → RSP_VALID=1 with the result after edge t (visible in cycle t+1).
- Throughput: one result per cycle while RSP_READY=1 continuously.
- Simultaneous consume and accept (RSP_VALID=1, RSP_READY=1, winner present): the old result retires and the new one loads at the same edge. RSP_VALID stays 1 with no bubble.
- Backpressure: with RSP_READY=0 the output register is frozen. No request is lost or duplicated.
- Reset mid-operation: an in-flight result is discarded and PTR returns to 0. Requesters must re-present after reset.
- Fairness: a continuously asserting requester is granted within NREQ accepts.

## Test plan
- Reset, then single request: requester 2 drives A=0x0000_0005, B=0x0000_0007, RSP_READY=1.
  - REQ_READY=4'b0100 for one cycle.
  - Next cycle: RSP_VALID=1, RSP_SUM=0x0000_000C, RSP_ID=2, PTR=3.
- Wrap-around: A=0xFFFF_FFFF, B=0x0000_0002 → RSP_SUM=0x0000_0001, with no other flag.
- Round-robin: all four REQ_VALID held high, RSP_READY=1, PTR=0.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - RSP_VALID stays 1 from the second cycle onward.
- Backpressure: result pending, RSP_READY=0 for 3 cycles while requester 1 is valid.
  - REQ_READY=0 throughout; RSP_SUM/RSP_ID are unchanged.
  - When RSP_READY rises, requester 1 is granted in that same cycle.
- Back-to-back: RSP_READY=1 with a new request from requester 3 in the consume cycle → RSP_VALID never drops and RSP_ID goes from 0 to 3.
- Asynchronous reset asserted mid-burst (between edges) → RSP_VALID=0, RSP_SUM=0, RSP_ID=0 immediately; after release, requester 0 wins first.
